dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequencer and two-port arbiter placed in front of the 512x64 data memory.
- The memory reads combinationally when its enable is 0 and writes level-sensitively when its enable is 1.
- Port 0 (core load/store) and port 1 (program loader/debug) issue single-word read/write requests; the block grants them round-robin.
- It drives the memory address and data from registers and opens the write window for exactly one cycle, after the address is stable. This prevents spurious writes on address glitches.

Parameters:
- ADDR_W, 64, request address width.
- DATA_W, 64, data width.
- MEM_AW, 9, memory index bits (depth 2^MEM_AW = 512).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  request valid for port 0 / port 1.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W each  word address.
- wdata0, wdata1  in  DATA_W each  write data.
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted and latched.
- done0, done1  out  1 each  one-cycle pulse: read data valid, or write committed.
- err0, err1  out  1 each  qualifies done; address out of range (optional feature only).
- rdata  out  DATA_W  read data, valid while doneN is high.
- mem_en  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_in  out  DATA_W  memory write data, registered.
- mem_out  in  DATA_W  memory read data, combinational.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; mem_en=0; mem_addr=0; mem_in=0; rdata=0.
  - All gnt, done and err outputs = 0.
  - last_grant=1, so port 0 wins first.
  - mem_en must fall combinationally on reset assertion, even mid-write.
- FSM states: IDLE, SETUP, WRITE, HOLD.
- IDLE:
  - Sample req0/req1 at the clock edge.
  - One requester: accept it.
  - Both requesting: accept the port that is not last_grant, then update last_grant.
  - On accept: latch port id, we, addr into mem_addr, wdata into mem_in. Next state = SETUP.
  - No request: remain in IDLE with mem_en=0.
- SETUP (cycle N+1 after acceptance edge N):
  - gntX=1; mem_en=0; address stable.
  - Read: capture mem_out into rdata at end of cycle; next state = IDLE; doneX=1 in cycle N+2. Read latency = 2 cycles from the req sample.
  - Write: next state = WRITE.
- WRITE (N+2): mem_en=1 for exactly this cycle; mem_addr and mem_in unchanged. Next state = HOLD.
- HOLD (N+3): mem_en=0; address still held; doneX=1. Next state = IDLE. Write ack latency = 3 cycles.
- Requester timing:
  - Address/data may change after the gnt cycle.
  - req must be low in the cycle done is high, otherwise a new request is accepted.
  - Requests are only sampled in IDLE; req held during a busy phase simply waits.
- Back-to-back: with both ports requesting continuously, grants alternate 0,1,0,1. There is no starvation; max wait is one other transaction.
- rdata holds its last value between reads; writes do not modify it.
- Address truncation: mem_addr carries the full address; the memory uses bits [MEM_AW-1:0], so the space wraps modulo 512.
- Reset during WRITE aborts the transaction: no done pulse, and a write in flight may or may not have committed.

Optional Feature:
- Macro: DMEM_ADDR_CHECK_EN.
- When defined:
  - A request with any nonzero addr bit at or above MEM_AW is an error.
  - The FSM goes IDLE -> SETUP -> IDLE with mem_en never asserted.
  - doneX=1 and errX=1 at N+2; rdata forced to 0.
- When undefined: err outputs are tied 0 and addresses wrap as described above.

Decomposition:
- Package tinker_mem_pkg:
  - FSM state encoding constants (IDLE=2'd0, SETUP=2'd1, WRITE=2'd2, HOLD=2'd3).
  - MEM_AW and MEM_DEPTH.
  - Port id constants PORT_CORE=0 and PORT_LOAD=1.
- Sub-module rr_arb2: two-input round-robin picker with last_grant register and update strobe, purely for arbitration. The FSM stays in dmem_arbiter.

Test Plan:
- Write then read, port 0:
  - Write addr 0x10, data 0xDEAD_BEEF_0000_0001 -> gnt0 at N+1, mem_en high only at N+2, done0 at N+3.
  - Read 0x10 -> done0 at N+2 with rdata=0xDEAD_BEEF_0000_0001.
- Simultaneous requests from reset: req0 and req1 both reading -> gnt0 first, then gnt1 on the next transaction; 4 paired transactions give grant order 0,1,0,1.
- Write glitch guard: during a write to addr 0x20, monitor every cycle -> mem_en never high while mem_addr differs from 0x20; no other memory word changes.
- Wrap-around, macro off: write 0x55 to addr 0x205 -> a read of addr 0x005 returns 0x55.
- Range check, macro on: read addr 0x200 -> done0=1, err0=1, rdata=0, mem_en stays 0. Write to 0x1000 -> no memory change, err0=1.
- Reset mid-write: assert reset during the WRITE cycle -> mem_en falls in the same cycle, no done pulse; after release, IDLE and port 0 wins the first grant.

Source files
------------

// File: rtl/tinker_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, memory geometry, port ids.
package tinker_mem_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StWrite = 2'd2,
        StHold  = 2'd3
    } state_e;

    localparam int unsigned MEM_AW    = 9;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. On a tie the port that did not win last time is chosen.
// last_grant resets to PORT_LOAD so that PORT_CORE wins the first tie.
module rr_arb2
    import tinker_mem_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic upd_i,
    output logic valid_o,
    output logic pick_o
);

    logic last_q, last_d;

    // Pick a winner and compute the next last_grant value.
    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            pick_o = ~last_q;
        end else if (req1_i) begin
            pick_o = PORT_LOAD;
        end else begin
            pick_o = PORT_CORE;
        end
        last_d = upd_i ? pick_o : last_q;
    end

    // last_grant register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= PORT_LOAD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port sequencer/arbiter in front of the 512x64 data memory.
// Address and write data are registered; the write enable is open for exactly one cycle
// (StWrite), one cycle after the address became stable, and decodes straight from the state
// register so an asynchronous reset drops it immediately.
// Optional: define DMEM_ADDR_CHECK_EN to reject addresses with bits set at or above MEM_AW.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned MEM_AW = tinker_mem_pkg::MEM_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);
    import tinker_mem_pkg::*;

    if (MEM_AW == 0 || MEM_AW >= ADDR_W) begin : g_cfg_check
        $error("dmem_arbiter: MEM_AW must be in 1..ADDR_W-1");
    end

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        done_q, done_d;

    logic              arb_valid, arb_pick, arb_upd;
    logic [ADDR_W-1:0] sel_addr;

`ifdef DMEM_ADDR_CHECK_EN
    logic              bad_q, bad_d;
    logic [1:0]        err_q, err_d;
`endif

    rr_arb2 u_arb (
        .clk_i   (clk),
        .rst_i   (reset),
        .req0_i  (req0),
        .req1_i  (req1),
        .upd_i   (arb_upd),
        .valid_o (arb_valid),
        .pick_o  (arb_pick)
    );

    assign sel_addr = (arb_pick == PORT_LOAD) ? addr1 : addr0;

    // Next-state logic: accept in idle, then sequence setup -> (write -> hold) -> idle.
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = '0;
        arb_upd = 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
        bad_d   = bad_q;
        err_d   = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    arb_upd = 1'b1;
                    port_d  = arb_pick;
                    we_d    = (arb_pick == PORT_LOAD) ? we1 : we0;
                    addr_d  = sel_addr;
                    wdata_d = (arb_pick == PORT_LOAD) ? wdata1 : wdata0;
`ifdef DMEM_ADDR_CHECK_EN
                    bad_d   = (sel_addr >> MEM_AW) != '0;
`endif
                    state_d = StSetup;
                end
            end
            StSetup: begin
`ifdef DMEM_ADDR_CHECK_EN
                if (bad_q) begin
                    // Out-of-range: finish like a read, never open the write window.
                    rdata_d        = '0;
                    done_d[port_q] = 1'b1;
                    err_d[port_q]  = 1'b1;
                    state_d        = StIdle;
                end else
`endif
                if (we_q) begin
                    state_d = StWrite;
                end else begin
                    rdata_d        = mem_out;
                    done_d[port_q] = 1'b1;
                    state_d        = StIdle;
                end
            end
            StWrite: begin
                done_d[port_q] = 1'b1;
                state_d        = StHold;
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            port_q  <= PORT_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= '0;
`ifdef DMEM_ADDR_CHECK_EN
            bad_q   <= 1'b0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
`ifdef DMEM_ADDR_CHECK_EN
            bad_q   <= bad_d;
            err_q   <= err_d;
`endif
        end
    end

    // Output decode.
    always_comb begin
        gnt0     = (state_q == StSetup) && (port_q == PORT_CORE);
        gnt1     = (state_q == StSetup) && (port_q == PORT_LOAD);
        mem_en   = (state_q == StWrite);
        done0    = done_q[0];
        done1    = done_q[1];
        rdata    = rdata_q;
        mem_addr = addr_q;
        mem_in   = wdata_q;
`ifdef DMEM_ADDR_CHECK_EN
        err0     = err_q[0];
        err1     = err_q[1];
`else
        err0     = 1'b0;
        err1     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 512x64 memory model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, err0, err1;
    logic [DW-1:0] rdata, mem_in, mem_out;
    logic          mem_en;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem  [512];
    logic [DW-1:0] snap [512];

    int            n_checks = 0;
    int            n_pass   = 0;
    int            en_cycles = 0;
    int            glitch    = 0;
    logic [AW-1:0] watch_addr = '0;

    dmem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .MEM_AW (9)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .err0     (err0),
        .err1     (err1),
        .rdata    (rdata),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, level-sensitive write.
    assign mem_out = mem[mem_addr[8:0]];
    always @(mem_en or mem_addr or mem_in) begin
        if (mem_en) mem[mem_addr[8:0]] = mem_in;
    end

    // Write-window monitor.
    always @(negedge clk) begin
        if (mem_en) begin
            en_cycles++;
            if (mem_addr !== watch_addr) glitch++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int count_diff(input int skip);
        int n = 0;
        for (int i = 0; i < 512; i++) begin
            if (i != skip && mem[i] !== snap[i]) n++;
        end
        return n;
    endfunction

    task automatic take_snap();
        for (int i = 0; i < 512; i++) snap[i] = mem[i];
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction; cycle indices count negedges after the accepting edge.
    task automatic xact(input logic p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int gnt_at, output int done_at,
                        output int en_at, output logic [DW-1:0] rd, output logic er);
        gnt_at = -1; done_at = -1; en_at = -1; rd = '0; er = 1'b0;
        @(negedge clk);
        if (p) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((p ? gnt1 : gnt0) && gnt_at < 0) begin
                gnt_at = c;
                req0 = 1'b0; req1 = 1'b0;
                // Inputs are free to change once granted.
                addr0 = ~a; addr1 = ~a; wdata0 = ~d; wdata1 = ~d;
            end
            if (mem_en && en_at < 0) en_at = c;
            if (p ? done1 : done0) begin
                done_at = c;
                rd = rdata;
                er = p ? err1 : err0;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    int            g, dn, e, ng, first, dcnt;
    logic [DW-1:0] rd;
    logic          er;
    int            order [4];

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 512; i++) mem[i] = {32'hA5A5_0000, i[31:0]};

        // Reset state.
        @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_in", mem_in, 0);
        check("rst_rdata", rdata, 0);
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_done", {done1, done0}, 0);
        check("rst_err", {err1, err0}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Port 0 write then read.
        watch_addr = 64'h10; en_cycles = 0;
        xact(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001, g, dn, e, rd, er);
        check("wr_gnt_at", g, 1);
        check("wr_en_at", e, 2);
        check("wr_done_at", dn, 3);
        check("wr_en_cycles", en_cycles, 1);
        check("wr_mem", mem[16], 64'hDEAD_BEEF_0000_0001);
        check("wr_err", er, 0);
        xact(1'b0, 1'b0, 64'h10, 64'h0, g, dn, e, rd, er);
        check("rd_gnt_at", g, 1);
        check("rd_done_at", dn, 2);
        check("rd_no_en", e, -1);
        check("rd_data", rd, 64'hDEAD_BEEF_0000_0001);

        // Simultaneous reads from reset: grants alternate starting with port 0.
        pulse_reset();
        mem[9'h30] = 64'h1111;
        mem[9'h31] = 64'h2222;
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h30;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h31;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                order[ng] = gnt1 ? 1 : 0;
                ng++;
            end
            if (done0) check("pair_rdata0", rdata, 64'h1111);
            if (done1) check("pair_rdata1", rdata, 64'h2222);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("pair_ngrants", ng, 4);
        check("pair_order0", order[0], 0);
        check("pair_order1", order[1], 1);
        check("pair_order2", order[2], 0);
        check("pair_order3", order[3], 1);
        repeat (3) @(negedge clk);

        // Glitch guard: port 1 write to 0x20 with inputs scrambled after grant.
        take_snap();
        watch_addr = 64'h20; en_cycles = 0; glitch = 0;
        xact(1'b1, 1'b1, 64'h20, 64'h00C0_FFEE, g, dn, e, rd, er);
        check("gl_gnt_at", g, 1);
        check("gl_done_at", dn, 3);
        check("gl_en_cycles", en_cycles, 1);
        check("gl_glitch", glitch, 0);
        check("gl_mem", mem[9'h20], 64'h00C0_FFEE);
        check("gl_other_words", count_diff(32), 0);
        check("gl_rdata_hold", rdata, 64'h2222);

`ifdef DMEM_ADDR_CHECK_EN
        // Out-of-range read and write.
        en_cycles = 0;
        xact(1'b0, 1'b0, 64'h200, 64'h0, g, dn, e, rd, er);
        check("rc_rd_done_at", dn, 2);
        check("rc_rd_err", er, 1);
        check("rc_rd_data", rd, 0);
        check("rc_rd_no_en", e, -1);
        take_snap();
        xact(1'b0, 1'b1, 64'h1000, 64'hBAD, g, dn, e, rd, er);
        check("rc_wr_done_at", dn, 2);
        check("rc_wr_err", er, 1);
        check("rc_wr_no_en", en_cycles, 0);
        check("rc_wr_no_change", count_diff(-1), 0);
`else
        // Address wrap-around modulo 512.
        watch_addr = 64'h205;
        xact(1'b0, 1'b1, 64'h205, 64'h55, g, dn, e, rd, er);
        check("wrap_wr_done_at", dn, 3);
        check("wrap_mem5", mem[5], 64'h55);
        xact(1'b0, 1'b0, 64'h005, 64'h0, g, dn, e, rd, er);
        check("wrap_rd_data", rd, 64'h55);
        check("wrap_rd_err", er, 0);
`endif

        // Reset during the write cycle.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 64'h40; wdata0 = 64'h77;
        @(negedge clk);
        check("mid_gnt", gnt0, 1);
        req0 = 1'b0;
        @(negedge clk);
        check("mid_en_before", mem_en, 1);
        reset = 1'b1;
        #1;
        check("mid_en_fall", mem_en, 0);
        dcnt = 0;
        @(negedge clk);
        if (done0 || done1) dcnt++;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done0 || done1) dcnt++;
        end
        check("mid_no_done", dcnt, 0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h30;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h31;
        first = 2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                first = gnt1 ? 1 : 0;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("mid_first_grant", first, 0);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
